// File: rtl/sdcard_blk_host.sv
// rtl/sdcard_blk_host.sv - host-side single-block sequencer for the sdcard phy FIFOs
//
// Moves exactly one BLKSZ-byte block per request between a local block buffer
// and the phy FIFOs.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i/req_we_i/req_blk_i request strobe, direction (1 = write), block number
//   busy_o, done_o, err_o   status: busy, completion pulse, sticky error
//   buf_*                   user window onto the block buffer (IDLE only)
//   cmd_*                   cmd FIFO push side
//   rx_*                    rx FIFO pop side (first-word-fall-through)
//   tx_*                    tx FIFO push side
//   blkcnt_i, err_i         card capacity in blocks, phy error
module sdcard_blk_host #(
  parameter int BLKSZ = 512
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          req_we_i,
  input  logic [31:0]   req_blk_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  input  logic [8:0]    buf_addr_i,
  input  logic          buf_we_i,
  input  logic [7:0]    buf_wdata_i,
  output logic [7:0]    buf_rdata_o,
  output logic          cmd_push_o,
  output logic          cmd_data_o,
  output logic [31:0]   cmd_addr_o,
  input  logic          cmd_full_i,
  output logic          rx_pop_o,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_empty_i,
  output logic          tx_push_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_full_i,
  input  logic [31:0]   blkcnt_i,
  input  logic          err_i
);

  localparam logic [8:0] LAST = 9'(BLKSZ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TXPRIME, S_TXFILL, S_WRCMD, S_WRWAIT, S_RDCMD, S_RDDRAIN, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [8:0]  cnt;
  logic        we_q;
  logic [31:0] blk_q;
  logic        err_q;
  logic [7:0]  mem [0:BLKSZ-1];
  logic [7:0]  rd_q;
  logic [8:0]  rd_addr;
  logic        mem_we;
  logic [8:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        out_of_range;

  assign out_of_range = (req_blk_i >= blkcnt_i);
  assign err_o        = err_q;
  assign cmd_data_o   = we_q;
  assign cmd_addr_o   = blk_q;
  assign tx_data_o    = rd_q;
  assign buf_rdata_o  = rd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req_i) begin
          if (err_q || out_of_range) state_nxt = S_DONE;
          else if (req_we_i)         state_nxt = S_TXPRIME;
          else                       state_nxt = S_RDCMD;
        end
      end
      S_TXPRIME: state_nxt = S_TXFILL;
      S_TXFILL:  if (!tx_full_i && cnt == LAST) state_nxt = S_WRCMD;
      S_WRCMD:   if (!cmd_full_i) state_nxt = S_WRWAIT;
      // The phy drain is invisible here; a write is complete once handed over.
      S_WRWAIT:  state_nxt = S_DONE;
      S_RDCMD:   if (!cmd_full_i) state_nxt = S_RDDRAIN;
      S_RDDRAIN: if (!rx_empty_i && cnt == LAST) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    // A phy error aborts any transfer in progress.
    if (err_i && state != S_IDLE)
      state_nxt = (state == S_DONE) ? S_IDLE : S_DONE;
  end

  always_comb begin
    busy_o     = (state != S_IDLE);
    done_o     = (state == S_DONE);
    cmd_push_o = 1'b0;
    rx_pop_o   = 1'b0;
    tx_push_o  = 1'b0;
    unique case (state)
      S_TXFILL:         tx_push_o  = !tx_full_i  && !err_i;
      S_WRCMD, S_RDCMD: cmd_push_o = !cmd_full_i && !err_i;
      S_RDDRAIN:        rx_pop_o   = !rx_empty_i && !err_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt   <= '0;
      we_q  <= 1'b0;
      blk_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_IDLE && req_i && !err_q) begin
        we_q  <= req_we_i;
        blk_q <= req_blk_i;
        cnt   <= '0;
        if (out_of_range) err_q <= 1'b1;
      end
      if (state != S_IDLE && err_i) err_q <= 1'b1;
      // 9-bit counter wraps to 0 after the last byte of the block.
      if (tx_push_o || rx_pop_o) cnt <= cnt + 9'd1;
      else if (cmd_push_o)       cnt <= '0;
    end
  end

  // Read address runs one byte ahead on a tx push so rd_q always holds the
  // byte at the counter while filling.
  always_comb begin
    rd_addr = cnt;
    if (state == S_IDLE) rd_addr = buf_addr_i;
    else if (tx_push_o)  rd_addr = cnt + 9'd1;
  end

  always_comb begin
    mem_we    = rx_pop_o || (state == S_IDLE && buf_we_i);
    mem_waddr = rx_pop_o ? cnt : buf_addr_i;
    mem_wdata = rx_pop_o ? rx_data_i : buf_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_sdcard_blk_host.sv
// tb/tb_sdcard_blk_host.sv - self-checking bench for sdcard_blk_host
module tb_sdcard_blk_host;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, req_i, req_we_i;
  logic [31:0] req_blk_i;
  logic        busy_o, done_o, err_o;
  logic [8:0]  buf_addr_i;
  logic        buf_we_i;
  logic [7:0]  buf_wdata_i, buf_rdata_o;
  logic        cmd_push_o, cmd_data_o;
  logic [31:0] cmd_addr_o;
  logic        cmd_full_i = 1'b0;
  logic        rx_pop_o;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_empty_i = 1'b1;
  logic        tx_push_o;
  logic [7:0]  tx_data_o;
  logic        tx_full_i = 1'b0;
  logic [31:0] blkcnt_i;
  logic        err_i;

  sdcard_blk_host dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_we_i(req_we_i), .req_blk_i(req_blk_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .buf_addr_i(buf_addr_i), .buf_we_i(buf_we_i), .buf_wdata_i(buf_wdata_i), .buf_rdata_o(buf_rdata_o),
    .cmd_push_o(cmd_push_o), .cmd_data_o(cmd_data_o), .cmd_addr_o(cmd_addr_o), .cmd_full_i(cmd_full_i),
    .rx_pop_o(rx_pop_o), .rx_data_i(rx_data_i), .rx_empty_i(rx_empty_i),
    .tx_push_o(tx_push_o), .tx_data_o(tx_data_o), .tx_full_i(tx_full_i),
    .blkcnt_i(blkcnt_i), .err_i(err_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] blk;
    logic [31:0] blkcnt;
    int          mul;
    int          xr;
    int          full_mode;
    logic        exp_err;
    int          exp_tx;
    int          exp_pop;
    int          exp_cmd;
  } vec_t;

  int n_vec = 0;
  int n_miss = 0;

  // Monitor state: only ever grows, the main sequence takes snapshots.
  int          cyc = 0, n_done = 0, n_cmd = 0, busy_low = 0, excl_bad = 0, cmd_cyc = 0;
  logic        cmd_we_seen = 1'b0;
  logic [31:0] cmd_blk_seen = '0;
  logic [7:0]  tx_log[$];
  int          tx_cyc[$];
  int          pop_cyc[$];
  logic        pend_pop = 1'b0;
  bit          mon_win = 1'b0;

  // Behavioural FIFO models
  logic [7:0]  rx_mem [0:8191];
  int          rx_wr = 0;
  int          rx_rd = 0;
  int          full_mode = 0;
  int          fcyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    pend_pop <= rx_pop_o;
    if (tx_push_o) begin tx_log.push_back(tx_data_o); tx_cyc.push_back(cyc); end
    if (rx_pop_o) pop_cyc.push_back(cyc);
    if (cmd_push_o) begin
      n_cmd <= n_cmd + 1; cmd_we_seen <= cmd_data_o; cmd_blk_seen <= cmd_addr_o; cmd_cyc <= cyc;
    end
    if (done_o) n_done <= n_done + 1;
    if (32'(tx_push_o) + 32'(rx_pop_o) + 32'(cmd_push_o) > 1) excl_bad <= excl_bad + 1;
    if (mon_win && !busy_o) busy_low <= busy_low + 1;
  end

  always @(posedge clk) begin
    #2;
    if (pend_pop) rx_rd = rx_rd + 1;
    rx_empty_i = (rx_rd == rx_wr);
    rx_data_i  = rx_mem[rx_rd & 8191];
    fcyc = fcyc + 1;
    case (full_mode)
      1:       begin tx_full_i = ((fcyc / 3) % 2) == 1; cmd_full_i = 1'b0; end
      2:       begin tx_full_i = ($urandom_range(0, 3) == 0); cmd_full_i = ($urandom_range(0, 1) == 0); end
      default: begin tx_full_i = 1'b0; cmd_full_i = 1'b0; end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(int i, int mul, int xr);
    return 8'((i * mul) ^ xr);
  endfunction

  // Reference rules: out-of-range or pre-existing error -> no transfer, error flagged.
  function automatic vec_t mk(logic we, logic [31:0] blk, logic [31:0] blkcnt,
                              int mul, int xr, int fm, logic prior_err);
    vec_t v;
    logic ok;
    v.we = we; v.blk = blk; v.blkcnt = blkcnt; v.mul = mul; v.xr = xr; v.full_mode = fm;
    v.exp_err = prior_err || (blk >= blkcnt);
    ok = !v.exp_err;
    v.exp_cmd = ok ? 1 : 0;
    v.exp_tx  = (ok && we)  ? 512 : 0;
    v.exp_pop = (ok && !we) ? 512 : 0;
    return v;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; err_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    rx_wr = rx_rd;
  endtask

  task automatic preload_rx(input int mul, input int xr);
    for (int i = 0; i < 512; i++) rx_mem[(rx_wr + i) & 8191] = pat(i, mul, xr);
    rx_wr = rx_wr + 512;
  endtask

  task automatic wait_pops(input int base, input int target);
    int c;
    for (c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (pop_cyc.size() - base == target) break;
    end
    if (c == 3000) chk("pop_wait_timeout", 32'(pop_cyc.size() - base), 32'(target));
  endtask

  task automatic run_row(input vec_t v, input bit do_rst, input int idx);
    logic [7:0] mb [0:511];
    int b_done, b_cmd, b_tx, b_pop, b_low, b_ex, bad, c;
    bit got;
    if (do_rst) do_reset();
    blkcnt_i = v.blkcnt;
    for (int i = 0; i < 512; i++) mb[i] = pat(i, v.mul, v.xr);
    if (v.exp_cmd != 0 && v.we) begin
      for (int i = 0; i < 512; i++) begin
        buf_addr_i = 9'(i); buf_wdata_i = mb[i]; buf_we_i = 1'b1;
        @(posedge clk); #1;
      end
      buf_we_i = 1'b0;
    end else if (v.exp_cmd != 0) begin
      preload_rx(v.mul, v.xr);
    end
    full_mode = v.full_mode;
    b_done = n_done; b_cmd = n_cmd; b_tx = tx_log.size(); b_pop = pop_cyc.size();
    b_low = busy_low; b_ex = excl_bad;
    req_we_i = v.we; req_blk_i = v.blk; req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0; mon_win = 1'b1;
    got = 1'b0;
    for (c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (n_done != b_done) begin got = 1'b1; break; end
    end
    mon_win = 1'b0; full_mode = 0;
    @(posedge clk); #1;
    chk($sformatf("r%0d_done_seen", idx), 32'(got), 1);
    chk($sformatf("r%0d_done_count", idx), 32'(n_done - b_done), 1);
    chk($sformatf("r%0d_err", idx), 32'(err_o), 32'(v.exp_err));
    chk($sformatf("r%0d_busy_end", idx), 32'(busy_o), 0);
    chk($sformatf("r%0d_busy_gap", idx), 32'(busy_low - b_low), 0);
    chk($sformatf("r%0d_strobe_excl", idx), 32'(excl_bad - b_ex), 0);
    chk($sformatf("r%0d_cmd_count", idx), 32'(n_cmd - b_cmd), 32'(v.exp_cmd));
    chk($sformatf("r%0d_tx_count", idx), 32'(tx_log.size() - b_tx), 32'(v.exp_tx));
    chk($sformatf("r%0d_pop_count", idx), 32'(pop_cyc.size() - b_pop), 32'(v.exp_pop));
    if (v.exp_cmd != 0 && n_cmd - b_cmd == 1) begin
      chk($sformatf("r%0d_cmd_data", idx), 32'(cmd_we_seen), 32'(v.we));
      chk($sformatf("r%0d_cmd_addr", idx), cmd_blk_seen, v.blk);
    end
    if (v.exp_tx == 512 && tx_log.size() - b_tx == 512) begin
      bad = 0;
      for (int i = 0; i < 512; i++) if (tx_log[b_tx + i] !== mb[i]) bad++;
      chk($sformatf("r%0d_tx_bytes_bad", idx), 32'(bad), 0);
      chk($sformatf("r%0d_tx_before_cmd", idx), 32'(tx_cyc[b_tx + 511] < cmd_cyc), 1);
    end
    if (v.exp_pop == 512 && pop_cyc.size() - b_pop == 512) begin
      chk($sformatf("r%0d_cmd_before_pop", idx), 32'(cmd_cyc < pop_cyc[b_pop]), 1);
      bad = 0;
      for (int i = 0; i < 512; i++) begin
        buf_addr_i = 9'(i);
        @(posedge clk); #1;
        if (buf_rdata_o !== mb[i]) bad++;
      end
      chk($sformatf("r%0d_readback_bad", idx), 32'(bad), 0);
    end
    rx_wr = rx_rd;
  endtask

  vec_t tab [12];
  int   b_pop, b_done;

  initial begin
    rst_i = 1'b1; req_i = 1'b0; req_we_i = 1'b0; req_blk_i = '0; err_i = 1'b0;
    buf_addr_i = '0; buf_we_i = 1'b0; buf_wdata_i = '0; blkcnt_i = 32'd1024;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_done", 32'(done_o), 0);
    chk("reset_err", 32'(err_o), 0);
    chk("reset_strobes", {29'd0, cmd_push_o, rx_pop_o, tx_push_o}, 0);
    @(posedge clk); #1;

    tab[0] = mk(1'b1, 32'd3,  32'd1024, 1, 8'h00, 0, 1'b0);
    tab[1] = mk(1'b0, 32'd7,  32'd1024, 1, 8'h5A, 0, 1'b0);
    tab[2] = mk(1'b1, 32'd5,  32'd8,    3, 8'h11, 1, 1'b0);
    tab[3] = mk(1'b1, 32'd16, 32'd16,   1, 8'h00, 0, 1'b0);
    tab[4] = mk(1'b0, 32'd15, 32'd16,   5, 8'hC3, 2, 1'b0);
    tab[5] = mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 1'b0);
    for (int i = 6; i < 12; i++)
      tab[i] = mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 80)),
                  32'($urandom_range(1, 64)), int'($urandom_range(1, 255)) | 1,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'b0);
    for (int i = 0; i < 12; i++) run_row(tab[i], 1'b1, i);

    // Sticky error: a later valid request only completes, then reset clears it.
    run_row(mk(1'b1, 32'd16, 32'd16, 1, 0, 0, 1'b0), 1'b1, 20);
    run_row(mk(1'b0, 32'd2,  32'd16, 1, 0, 0, 1'b1), 1'b0, 21);
    do_reset();
    @(negedge clk);
    chk("sticky_cleared_by_reset", 32'(err_o), 0);
    @(posedge clk); #1;

    // Phy error at byte 100 of a read.
    do_reset();
    blkcnt_i = 32'd1024;
    preload_rx(1, 8'h5A);
    b_pop = pop_cyc.size(); b_done = n_done;
    req_we_i = 1'b0; req_blk_i = 32'd9; req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    wait_pops(b_pop, 100);
    err_i = 1'b1;
    @(negedge clk);
    chk("err_pop_suppressed", 32'(rx_pop_o), 0);
    @(posedge clk); #1;
    err_i = 1'b0;
    @(negedge clk);
    chk("err_done_next", 32'(done_o), 1);
    chk("err_flag_set", 32'(err_o), 1);
    @(posedge clk); #1;
    chk("err_pop_total", 32'(pop_cyc.size() - b_pop), 100);
    chk("err_done_total", 32'(n_done - b_done), 1);
    chk("err_idle_after", 32'(busy_o), 0);
    buf_addr_i = 9'd99;
    @(posedge clk); #1;
    chk("err_byte99", 32'(buf_rdata_o), 32'(pat(99, 1, 8'h5A)));
    rx_wr = rx_rd;

    // Reset in the middle of a read drain.
    do_reset();
    preload_rx(7, 8'h33);
    b_pop = pop_cyc.size();
    req_we_i = 1'b0; req_blk_i = 32'd1; req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    wait_pops(b_pop, 200);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_strobes", {28'd0, cmd_push_o, rx_pop_o, tx_push_o, done_o}, 0);
    chk("midrst_err", 32'(err_o), 0);
    @(posedge clk); #1;
    rx_wr = rx_rd;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
